stack_exec_unit: RTL and testbench
==================================

# stack_exec_unit

Parametrised stack-machine execution unit: a LIFO operand stack, two internal operand registers and an ALU, sequenced by an internal FSM from a valid/ready command port. Successor to the fixed 16-bit datapath. The control unit no longer drives the stack, temp-register and ALU strobes individually; it issues one command per transaction. The block adds configurable width and depth, overflow/underflow detection, DUP/SWAP, and a single clock domain.

## Interface
- WIDTH, 16, data word width (≥4)
- DEPTH, 16, stack entries (power of 2, ≥4)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_op  in  3  NOP=0, PUSH=1, POP=2, DUP=3, SWAP=4, ALU=5 (6,7 treated as NOP)
- cmd_data  in  WIDTH  immediate for PUSH
- alu_op  in  5  ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, EQ=6, LT=7 (unsigned); others yield result 0
- clear_err  in  1  synchronous clear of sticky error flags
- top  out  WIDTH  current top-of-stack (0 when empty)
- depth  out  $clog2(DEPTH)+1  number of occupied entries
- flag  out  1  ALU condition bit, updated only by ALU commands
- done  out  1  one-cycle pulse when a command completes
- overflow, underflow  out  1  sticky error flags

## Operation
- Reset values: depth=0, top=0, flag=0, done=0, overflow=underflow=0, FSM=IDLE, cmd_ready=1.
- cmd_ready is high only in IDLE.
- PUSH: write cmd_data at sp; depth+1. If depth==DEPTH, set overflow and leave the stack unchanged.
- POP: depth−1, discard the value. If empty, set underflow and leave the stack unchanged.
- DUP: push a copy of top. Needs depth≥1, else underflow; full stack gives overflow.
- SWAP: exchange top and top−1. Needs depth≥2, else underflow.
- ALU: B=top, A=entry below. Result = A op B (SUB = A−B mod 2^WIDTH). Both operands are popped and the result is pushed, so net depth is −1.
  - NOT is unary: pops B only, pushes ~B, net depth 0.
  - EQ/LT: result = {WIDTH−1 zeros, cond}; flag=cond.
  - ADD/SUB: flag=carry/borrow out.
  - Logic ops: flag=(result==0).
- Operand check for ALU happens in IDLE at acceptance. If depth is insufficient (2, or 1 for NOT), set underflow, take no FSM sequence, leave stack and flag unchanged, and pulse done.
- FSM: IDLE → POP_B (top→opB) → POP_A (top→opA; skipped for NOT) → EXEC (compute into result register, update flag) → PUSH_R (write result) → IDLE.
- Error commands still complete: they pulse done.
- clear_err has priority over an error set in the same cycle.
- Reset at any point aborts the FSM and empties the stack.

## Timing
- PUSH/POP/DUP/SWAP/NOP/rejected ALU: accepted at edge N; top/depth/error updated at N; done=1 for cycle N→N+1; cmd_ready stays 1. Back-to-back commands sustain one per cycle.
- ALU binary: accepted at edge N; cmd_ready=0 for 4 cycles. Result is on top and done=1 after edge N+4. The next command can be accepted at edge N+5.
- ALU NOT: 3 busy cycles (POP_A skipped).
- top is registered-path only; there is no combinational path from cmd_* to top, depth or flag.
- During ALU, top/depth show intermediate pops.

## Structure
- Package stack_exec_pkg: cmd_op and alu_op encodings, FSM state enum, flag rules as constants.
- Sub-module stack_exec_alu: purely combinational, (A, B, alu_op) → (result, cond). Instantiated once.
- Stack storage is a register array with an sp counter.

## Test plan
- Reset, then PUSH 5, PUSH 3, ALU SUB → top=2, depth=1, flag=0, done 4 cycles after acceptance.
- PUSH 3, PUSH 5, ALU SUB → top=0xFFFE, flag=1 (borrow). Then PUSH 0xFFFE, ALU EQ → top=1, flag=1, depth=1.
- Fill DEPTH entries, PUSH once more → overflow=1, depth=DEPTH, top unchanged. Then clear_err → overflow=0.
- Empty stack, POP → underflow=1, depth=0. Then a single PUSH 7 and ALU ADD → underflow stays 1, top=7, done 1 cycle after acceptance, FSM not entered.
- PUSH 1, PUSH 2, SWAP, DUP → stack top-down 1,1,2, depth=3. Back-to-back with cmd_valid held high: one command completes per cycle.
- Assert reset during POP_A of an ALU command → depth=0, top=0, cmd_ready=1 immediately, done=0.

Source files
------------

// File: rtl/stack_exec_pkg.sv
// Shared encodings for the stack execution unit: commands, ALU ops,
// sequencer states and the rule that picks each ALU op's flag source.
package stack_exec_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_ALU  = 3'd5
    } cmd_op_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_NOT = 5'd5,
        ALU_EQ  = 5'd6,
        ALU_LT  = 5'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_B,
        S_POP_A,
        S_EXEC,
        S_PUSH_R
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_CARRY,
        FR_COND,
        FR_ZERO
    } flag_rule_e;

    function automatic flag_rule_e flag_rule(input logic [4:0] op);
        case (op)
            ALU_ADD, ALU_SUB:                   return FR_CARRY;
            ALU_EQ, ALU_LT:                     return FR_COND;
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOT:  return FR_ZERO;
            default:                            return FR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stack_exec_unit_alu.sv
// Combinational ALU: result = A op B, cond chosen by the op's flag rule.
module stack_exec_alu
    import stack_exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cond
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        dif    = {1'b0, a} - {1'b0, b};
        result = '0;
        cond   = 1'b0;
        case (op)
            ALU_ADD: result = sum[WIDTH-1:0];
            ALU_SUB: result = dif[WIDTH-1:0];
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~b;
            ALU_EQ:  result = {{(WIDTH-1){1'b0}}, a == b};
            ALU_LT:  result = {{(WIDTH-1){1'b0}}, a < b};
            default: result = '0;
        endcase
        // dif MSB is the borrow, set exactly when a < b
        case (flag_rule(op))
            FR_CARRY: cond = (op == ALU_SUB) ? dif[WIDTH] : sum[WIDTH];
            FR_COND:  cond = result[0];
            FR_ZERO:  cond = (result == '0);
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/stack_exec_unit.sv
// Stack-machine execution unit: LIFO operand stack, operand registers and
// ALU, sequenced from a one-command-per-transaction valid/ready port.
module stack_exec_unit
    import stack_exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_data,
    input  logic [4:0]               alu_op,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     flag,
    output logic                     done,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    typedef logic [DW-1:0] cnt_t;

    logic [WIDTH-1:0] stk [DEPTH];
    cnt_t             sp;
    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, res_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cond;
    logic [4:0]       op_q;

    logic             empty, full, two;
    logic [AW-1:0]    tix, bix, six;

    logic             wr_en, sw_en, sp_inc, sp_dec;
    logic [WIDTH-1:0] wr_val;
    logic             ld_a, ld_b, ld_r;
    logic             set_ovf, set_unf, done_nx;

    assign empty     = (sp == '0);
    assign full      = (sp == cnt_t'(DEPTH));
    assign two       = (sp >= cnt_t'(2));
    assign tix       = AW'(sp - cnt_t'(1));
    assign bix       = AW'(sp - cnt_t'(2));
    assign six       = AW'(sp);
    assign top       = empty ? '0 : stk[tix];
    assign depth     = sp;
    assign cmd_ready = (state == S_IDLE);

    stack_exec_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_q),
        .result (alu_res),
        .cond   (alu_cond)
    );

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_val   = cmd_data;
        sw_en    = 1'b0;
        sp_inc   = 1'b0;
        sp_dec   = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_r     = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            S_IDLE: if (cmd_valid) begin
                done_nx = 1'b1;
                case (cmd_op)
                    OP_PUSH: begin
                        if (full) set_ovf = 1'b1;
                        else begin
                            wr_en  = 1'b1;
                            sp_inc = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (empty) set_unf = 1'b1;
                        else       sp_dec  = 1'b1;
                    end
                    OP_DUP: begin
                        if (empty)     set_unf = 1'b1;
                        else if (full) set_ovf = 1'b1;
                        else begin
                            wr_en  = 1'b1;
                            wr_val = top;
                            sp_inc = 1'b1;
                        end
                    end
                    OP_SWAP: begin
                        if (!two) set_unf = 1'b1;
                        else      sw_en   = 1'b1;
                    end
                    OP_ALU: begin
                        // operands are checked up front so a short stack
                        // never enters the sequence
                        if (empty || (!two && alu_op != ALU_NOT)) begin
                            set_unf = 1'b1;
                        end else begin
                            done_nx  = 1'b0;
                            state_nx = S_POP_B;
                        end
                    end
                    default: ;
                endcase
            end
            S_POP_B: begin
                ld_b     = 1'b1;
                sp_dec   = 1'b1;
                state_nx = (op_q == ALU_NOT) ? S_EXEC : S_POP_A;
            end
            S_POP_A: begin
                ld_a     = 1'b1;
                sp_dec   = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                ld_r     = 1'b1;
                state_nx = S_PUSH_R;
            end
            S_PUSH_R: begin
                wr_en    = 1'b1;
                wr_val   = res_q;
                sp_inc   = 1'b1;
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) stk[six] <= wr_val;
        if (sw_en) begin
            stk[tix] <= stk[bix];
            stk[bix] <= stk[tix];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sp        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            op_q      <= '0;
            flag      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (sp_inc)      sp <= sp + cnt_t'(1);
            else if (sp_dec) sp <= sp - cnt_t'(1);
            if (state == S_IDLE) op_q <= alu_op;
            if (ld_b) op_b <= top;
            if (ld_a) op_a <= top;
            if (ld_r) begin
                res_q <= alu_res;
                flag  <= alu_cond;
            end
            if (clear_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (set_ovf) overflow  <= 1'b1;
                if (set_unf) underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_exec_unit.sv
// Self-checking bench for stack_exec_unit: directed scenarios plus random
// command streams checked against a queue-based reference model.
module tb_stack_exec_unit;

    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         clear_err = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_data = '0;
    logic [4:0]   alu_op = '0;
    logic         cmd_ready, flag, done, overflow, underflow;
    logic [W-1:0] top;
    logic [4:0]   depth;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] q[$];
    logic         m_flag = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    always #5 clk = ~clk;

    stack_exec_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_op    (alu_op),
        .clear_err (clear_err),
        .top       (top),
        .depth     (depth),
        .flag      (flag),
        .done      (done),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [W-1:0] d,
                         input logic [4:0] a, input logic clr,
                         output int lat);
        bit           e_o, e_u;
        logic [W-1:0] x, y, r;
        logic [W:0]   s;
        int           need;
        e_o = 0;
        e_u = 0;
        lat = 0;
        x   = '0;
        case (op)
            3'd1: if (q.size() == D) e_o = 1; else q.push_back(d);
            3'd2: if (q.size() == 0) e_u = 1; else void'(q.pop_back());
            3'd3: begin
                if (q.size() == 0)      e_u = 1;
                else if (q.size() == D) e_o = 1;
                else q.push_back(q[$]);
            end
            3'd4: begin
                if (q.size() < 2) e_u = 1;
                else begin
                    x = q.pop_back();
                    y = q.pop_back();
                    q.push_back(x);
                    q.push_back(y);
                end
            end
            3'd5: begin
                need = (a == 5) ? 1 : 2;
                if (q.size() < need) e_u = 1;
                else begin
                    y = q.pop_back();
                    if (need == 2) x = q.pop_back();
                    lat = (need == 2) ? 4 : 3;
                    case (a)
                        5'd0: begin
                            s = {1'b0, x} + {1'b0, y};
                            r = s[W-1:0];
                            m_flag = s[W];
                        end
                        5'd1: begin r = x - y; m_flag = (x < y); end
                        5'd2: begin r = x & y; m_flag = (r == 0); end
                        5'd3: begin r = x | y; m_flag = (r == 0); end
                        5'd4: begin r = x ^ y; m_flag = (r == 0); end
                        5'd5: begin r = ~y; m_flag = (r == 0); end
                        5'd6: begin r = W'(x == y); m_flag = (x == y); end
                        5'd7: begin r = W'(x < y); m_flag = (x < y); end
                        default: begin r = '0; m_flag = 1'b0; end
                    endcase
                    q.push_back(r);
                end
            end
            default: ;
        endcase
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (e_o) m_ovf = 1;
            if (e_u) m_unf = 1;
        end
    endtask

    task automatic check_state(input string tag);
        logic [W-1:0] et;
        et = (q.size() != 0) ? q[$] : '0;
        check({tag, "_top"}, 32'(top), 32'(et));
        check({tag, "_depth"}, 32'(depth), 32'(q.size()));
        check({tag, "_flag"}, 32'(flag), 32'(m_flag));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [W-1:0] d, input logic [4:0] a,
                         input logic clr, input bit keep);
        int lat, exp_lat;
        @(negedge clk);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        alu_op    = a;
        clear_err = clr;
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
        clear_err = 1'b0;
        model(op, d, a, clr, exp_lat);
        lat = 0;
        while (!done && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_state(tag);
    endtask

    task automatic drain();
        while (q.size() != 0) issue("drain", 3'd2, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] d;
        logic [4:0]   a;
        logic         clr;
        int           sel;

        #12;
        check("rst_top", 32'(top), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        issue("p5", 3'd1, 16'd5, '0, 1'b0, 1'b0);
        issue("p3", 3'd1, 16'd3, '0, 1'b0, 1'b0);
        issue("sub", 3'd5, '0, 5'd1, 1'b0, 1'b0);
        check("sub_val", 32'(top), 32'd2);
        drain();

        issue("p3b", 3'd1, 16'd3, '0, 1'b0, 1'b0);
        issue("p5b", 3'd1, 16'd5, '0, 1'b0, 1'b0);
        issue("subb", 3'd5, '0, 5'd1, 1'b0, 1'b0);
        check("borrow_val", 32'(top), 32'h0000_FFFE);
        check("borrow_flag", 32'(flag), 32'd1);
        issue("pfe", 3'd1, 16'hFFFE, '0, 1'b0, 1'b0);
        issue("eq", 3'd5, '0, 5'd6, 1'b0, 1'b0);
        check("eq_val", 32'(top), 32'd1);
        drain();

        for (int i = 0; i < D; i++)
            issue("fill", 3'd1, W'(i * 7 + 1), '0, 1'b0, 1'b0);
        issue("ovf", 3'd1, 16'hBEEF, '0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        issue("clr", 3'd0, '0, '0, 1'b1, 1'b0);
        check("ovf_clr", 32'(overflow), 32'd0);
        drain();

        issue("unf", 3'd2, '0, '0, 1'b0, 1'b0);
        check("unf_set", 32'(underflow), 32'd1);
        issue("p7", 3'd1, 16'd7, '0, 1'b0, 1'b0);
        issue("add_rej", 3'd5, '0, 5'd0, 1'b0, 1'b0);
        check("rej_top", 32'(top), 32'd7);
        drain();
        issue("clr2", 3'd0, '0, '0, 1'b1, 1'b0);

        issue("bb1", 3'd1, 16'd1, '0, 1'b0, 1'b1);
        issue("bb2", 3'd1, 16'd2, '0, 1'b0, 1'b1);
        issue("bbsw", 3'd4, '0, '0, 1'b0, 1'b1);
        issue("bbdup", 3'd3, '0, '0, 1'b0, 1'b0);
        check("bb_depth", 32'(depth), 32'd3);
        check("bb_top", 32'(top), 32'd1);
        drain();

        issue("r_p4", 3'd1, 16'd4, '0, 1'b0, 1'b0);
        issue("r_p9", 3'd1, 16'd9, '0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        alu_op    = 5'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_depth", 32'(depth), 32'd0);
        check("ar_top", 32'(top), 32'd0);
        check("ar_ready", 32'(cmd_ready), 32'd1);
        check("ar_done", 32'(done), 32'd0);
        q.delete();
        m_flag = 0;
        m_ovf  = 0;
        m_unf  = 0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            d   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                               : W'($urandom);
            a   = 5'($urandom_range(0, 7));
            clr = ($urandom_range(0, 7) == 0);
            case (sel)
                0, 1, 2: op = 3'd1;
                3:       op = 3'd2;
                4:       op = 3'd3;
                5:       op = 3'd4;
                6, 7, 8: op = 3'd5;
                default: op = 3'($urandom_range(0, 1) * 6);
            endcase
            issue("rnd", op, d, a, clr, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
